// File: rtl/tx_frame_sequencer_pkg.sv
// Shared definitions for the 802.11a TX frame sequencer: states, field codes,
// rate table and the SIGNAL field builder.
package tx_frame_sequencer_pkg;

    typedef enum logic [3:0] {
        ST_IDLE, ST_CALC, ST_PRE, ST_SIG, ST_SVC, ST_DATA, ST_TAIL, ST_PAD, ST_DONE
    } state_t;

    typedef enum logic [2:0] {
        FLD_PRE  = 3'd0,
        FLD_SIG  = 3'd1,
        FLD_SVC  = 3'd2,
        FLD_DATA = 3'd3,
        FLD_TAIL = 3'd4,
        FLD_PAD  = 3'd5
    } field_t;

    localparam int SIG_BITS  = 24;
    localparam int SVC_BITS  = 16;
    localparam int TAIL_BITS = 6;
    localparam int SIG_LEN_W = 12;

    // Data bits per OFDM symbol; 0 marks a code that is not a legal rate.
    function automatic logic [7:0] ndbps_of(input logic [3:0] rate);
        case (rate)
            4'b1101: return 8'd24;
            4'b1111: return 8'd36;
            4'b0101: return 8'd48;
            4'b0111: return 8'd72;
            4'b1001: return 8'd96;
            4'b1011: return 8'd144;
            4'b0001: return 8'd192;
            4'b0011: return 8'd216;
            default: return 8'd0;
        endcase
    endfunction

    function automatic logic rate_ok(input logic [3:0] rate);
        return ndbps_of(rate) != 8'd0;
    endfunction

    // SIGNAL word, MSB transmitted first: RATE[3..0], reserved, LENGTH LSB first,
    // even parity over the first 17 bits, six tail zeros.
    function automatic logic [SIG_BITS-1:0] signal_word(input logic [3:0] rate,
                                                        input logic [SIG_LEN_W-1:0] len);
        logic [16:0] head;
        head[16:12] = {rate, 1'b0};
        for (int i = 0; i < SIG_LEN_W; i++) head[11-i] = len[i];
        return {head, ^head, 6'b000000};
    endfunction

endpackage

// File: rtl/tx_frame_sequencer_pad_calc.sv
// Iterative subtract-divider: from rem = 8*L+22 derives the DATA symbol count
// and the number of PAD bits needed to fill the last symbol.
module tx_frame_sequencer_pad_calc #(
    parameter int CNT_W = 16
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             start,
    input  logic             abort,
    input  logic [7:0]       ndbps,
    input  logic [CNT_W-1:0] rem_init,
    output logic             done,
    output logic [7:0]       n_pad,
    output logic [CNT_W-1:0] n_sym
);

    logic             busy;
    logic [CNT_W-1:0] rem_q;
    logic [CNT_W-1:0] quot_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            busy   <= 1'b0;
            done   <= 1'b0;
            rem_q  <= '0;
            quot_q <= '0;
            n_pad  <= '0;
            n_sym  <= '0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                busy <= 1'b0;
            end else if (start) begin
                busy   <= 1'b1;
                rem_q  <= rem_init;
                quot_q <= '0;
            end else if (busy) begin
                if (rem_q > CNT_W'(ndbps)) begin
                    rem_q  <= rem_q - CNT_W'(ndbps);
                    quot_q <= quot_q + 1'b1;
                end else begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    n_pad <= ndbps - rem_q[7:0];
                    n_sym <= quot_q + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/tx_frame_sequencer.sv
// Serialises one 802.11a PPDU (PRE, SIG, SVC, DATA, TAIL, PAD) with valid/ready
// handshakes on both the payload and the output side.
module tx_frame_sequencer
    import tx_frame_sequencer_pkg::*;
#(
    parameter int                 PRE_LEN     = 12,
    parameter logic [PRE_LEN-1:0] PRE_PATTERN = {PRE_LEN{1'b1}},
    parameter logic [6:0]         SEED        = 7'b1011101,
    parameter int                 LEN_W       = 12,
    parameter int                 CNT_W       = 16
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             iStart,
    input  logic [3:0]       iRate,
    input  logic [LEN_W-1:0] iLength,
    input  logic             iAbort,
    input  logic             iData,
    input  logic             iDataValid,
    output logic             oDataReady,
    output logic             oBit,
    output logic             oBitValid,
    input  logic             iBitReady,
    output logic [2:0]       oField,
    output logic             oScrEn,
    output logic             oSeedLoad,
    output logic [6:0]       oSeed,
    output logic             oRateLoad,
    output logic [3:0]       oRate,
    output logic [CNT_W-1:0] oNSym,
    output logic             oBusy,
    output logic             oDone,
    output logic             oErr
);

    state_t                 state_q, state_d;
    logic [3:0]             rate_q;
    logic [SIG_LEN_W-1:0]   len_q, len_in;
    logic [SIG_BITS-1:0]    sig_sr;
    logic [PRE_LEN-1:0]     pre_sr;
    logic [CNT_W-1:0]       cnt_q, field_len;
    logic                   err_q, calc_start_q;
    logic                   len_wide, start_ok, bit_state, xfer, advance;
    logic                   div_done;
    logic [7:0]             n_pad;

    // Lengths wider than the 12-bit SIGNAL field cannot be encoded.
    if (LEN_W > SIG_LEN_W) begin : g_len_wide
        assign len_in   = iLength[SIG_LEN_W-1:0];
        assign len_wide = |iLength[LEN_W-1:SIG_LEN_W];
    end else begin : g_len_narrow
        assign len_in   = SIG_LEN_W'(iLength);
        assign len_wide = 1'b0;
    end

    assign start_ok  = rate_ok(iRate) && (len_in != '0) && !len_wide;
    assign bit_state = state_q inside {ST_PRE, ST_SIG, ST_SVC, ST_TAIL, ST_PAD};
    assign oBitValid = (state_q == ST_DATA) ? iDataValid : bit_state;
    assign xfer      = oBitValid & iBitReady;
    assign advance   = xfer && (cnt_q == CNT_W'(1));

    tx_frame_sequencer_pad_calc #(.CNT_W(CNT_W)) u_pad_calc (
        .iClk     (iClk),
        .iRst     (iRst),
        .start    (calc_start_q),
        .abort    (iAbort && (state_q != ST_IDLE)),
        .ndbps    (ndbps_of(rate_q)),
        .rem_init (CNT_W'({len_q, 3'b000}) + CNT_W'(22)),
        .done     (div_done),
        .n_pad    (n_pad),
        .n_sym    (oNSym)
    );

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        // NOTE: every signal written here gets a default first so no latch is inferred.
        state_d    = state_q;
        oBit       = 1'b0;
        oField     = FLD_PRE;
        oScrEn     = 1'b0;
        oDataReady = 1'b0;
        case (state_q)
            ST_IDLE: if (iStart && start_ok) state_d = ST_CALC;
            ST_CALC: if (div_done) state_d = ST_PRE;
            ST_PRE: begin
                oBit = pre_sr[PRE_LEN-1];
                if (advance) state_d = ST_SIG;
            end
            ST_SIG: begin
                oBit   = sig_sr[SIG_BITS-1];
                oField = FLD_SIG;
                if (advance) state_d = ST_SVC;
            end
            ST_SVC: begin
                oField = FLD_SVC;
                oScrEn = 1'b1;
                if (advance) state_d = ST_DATA;
            end
            ST_DATA: begin
                oBit       = iData;
                oField     = FLD_DATA;
                oScrEn     = 1'b1;
                oDataReady = iBitReady;
                if (advance) state_d = ST_TAIL;
            end
            ST_TAIL: begin
                oField = FLD_TAIL;
                if (advance) state_d = (n_pad == 8'd0) ? ST_DONE : ST_PAD;
            end
            ST_PAD: begin
                oField = FLD_PAD;
                oScrEn = 1'b1;
                if (advance) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (iAbort && (state_q != ST_IDLE)) state_d = ST_IDLE;
    end

    // Length of the field being entered; loaded into the bit counter on entry.
    always_comb begin
        case (state_d)
            ST_PRE:  field_len = CNT_W'(PRE_LEN);
            ST_SIG:  field_len = CNT_W'(SIG_BITS);
            ST_SVC:  field_len = CNT_W'(SVC_BITS);
            ST_DATA: field_len = CNT_W'({len_q, 3'b000});
            ST_TAIL: field_len = CNT_W'(TAIL_BITS);
            ST_PAD:  field_len = CNT_W'(n_pad);
            default: field_len = '0;
        endcase
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            rate_q       <= '0;
            len_q        <= '0;
            sig_sr       <= '0;
            pre_sr       <= '0;
            cnt_q        <= '0;
            err_q        <= 1'b0;
            calc_start_q <= 1'b0;
        end else begin
            err_q        <= (state_q == ST_IDLE) ? (iStart && !start_ok) : iAbort;
            calc_start_q <= (state_q == ST_IDLE) && iStart && start_ok;
            if ((state_q == ST_IDLE) && iStart) begin
                rate_q <= iRate;
                len_q  <= len_in;
                sig_sr <= signal_word(iRate, len_in);
            end
            if (state_d != state_q) cnt_q <= field_len;
            else if (xfer)          cnt_q <= cnt_q - 1'b1;
            if ((state_d == ST_PRE) && (state_q != ST_PRE))  pre_sr <= PRE_PATTERN;
            else if ((state_q == ST_PRE) && xfer)            pre_sr <= pre_sr << 1;
            if ((state_q == ST_SIG) && xfer) sig_sr <= sig_sr << 1;
        end
    end

    assign oSeed     = SEED;
    assign oSeedLoad = (state_q == ST_SIG) && advance;
    assign oRateLoad = (state_q == ST_CALC) && div_done;
    assign oRate     = rate_q;
    assign oBusy     = (state_q != ST_IDLE);
    assign oDone     = (state_q == ST_DONE) && !iAbort;
    assign oErr      = err_q;

endmodule
